// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_pkg                                                        |
// | Brief   : Shared FSM encodings, latency counter width and error codes    |
// |           for the handshaked data memory and the load/store unit.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int c_lat_cnt_w = 4;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_RANGE    = 2'd2
   } err_code_t;

endpackage
`default_nettype wire

// File: rtl/mem_bank_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_bank_array                                                 |
// | Brief   : DEPTH x DATA_W storage, byte-enabled write port, registered    |
// |           read port. Contents are never reset.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_bank_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic                       re,
   input  logic [$clog2(DEPTH)-1:0]   addr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [DATA_W/8-1:0]        be,
   output logic [DATA_W-1:0]          rdata
);

   localparam int c_be_w = DATA_W / 8;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < c_be_w; i++) begin
            if (be[i]) begin
               r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
   end

   // Read register only moves on a read commit, so it holds through backpressure.
   always_ff @(posedge clk) begin
      if (re) begin
         r_rdata <= r_mem[addr];
      end
   end

   assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_bank_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_bank_hs                                                    |
// | Brief   : Single-port data memory with valid/ready request and response  |
// |           channels, byte enables, configurable latency, error reporting. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_bank_hs
   import mem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err
);

   localparam int c_be_w  = DATA_W / 8;
   localparam int c_off   = $clog2(c_be_w);
   localparam int c_idx_w = $clog2(DEPTH);
   localparam logic [c_lat_cnt_w-1:0] c_lat = c_lat_cnt_w'(LATENCY);

   state_t                   r_state;
   state_t                   w_next_state;
   logic [c_lat_cnt_w-1:0]   r_cnt;
   logic [c_lat_cnt_w-1:0]   w_next_cnt;
   logic                     w_commit;

   logic                     r_write;
   logic [ADDR_W-1:0]        r_addr;
   logic [DATA_W-1:0]        r_wdata;
   logic [c_be_w-1:0]        r_be;
   logic                     r_err;
   logic                     r_rd_sel;

   logic                     w_accept;
   logic                     w_cur_write;
   logic [ADDR_W-1:0]        w_cur_addr;
   logic [DATA_W-1:0]        w_cur_wdata;
   logic [c_be_w-1:0]        w_cur_be;
   logic                     w_misalign;
   logic                     w_range;
   logic                     w_err;
   logic [c_idx_w-1:0]       w_index;
   logic [DATA_W-1:0]        w_arr_rdata;

   assign w_accept = (r_state == ST_IDLE) && req_valid;

   // With zero latency the commit happens on the accept edge, so decode the live request.
   assign w_cur_write = (r_state == ST_IDLE) ? req_write : r_write;
   assign w_cur_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
   assign w_cur_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
   assign w_cur_be    = (r_state == ST_IDLE) ? req_be    : r_be;

   generate
      if (c_off > 0) begin : g_misalign
         assign w_misalign = |w_cur_addr[c_off-1:0];
      end else begin : g_byte_words
         assign w_misalign = 1'b0;
      end
   endgenerate

   assign w_range = |(w_cur_addr >> (c_off + c_idx_w));
   assign w_err   = w_misalign | w_range;
   assign w_index = w_cur_addr[c_off +: c_idx_w];

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (LATENCY == 0) begin
                  w_next_state = ST_RESP;
                  w_commit     = 1'b1;
               end else begin
                  w_next_state = ST_WAIT;
                  w_next_cnt   = c_lat_cnt_w'(1);
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == c_lat) begin
               w_next_state = ST_RESP;
               w_next_cnt   = '0;
               w_commit     = 1'b1;
            end else begin
               w_next_cnt = r_cnt + 1'b1;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_be     <= '0;
         r_err    <= 1'b0;
         r_rd_sel <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
         end
         if (w_commit) begin
            r_err    <= w_err;
            r_rd_sel <= ~w_cur_write & ~w_err;
         end else if ((r_state == ST_RESP) && resp_ready) begin
            r_err    <= 1'b0;
            r_rd_sel <= 1'b0;
         end
      end
   end

   mem_bank_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (w_commit & w_cur_write & ~w_err),
      .re    (w_commit & ~w_cur_write & ~w_err),
      .addr  (w_index),
      .wdata (w_cur_wdata),
      .be    (w_cur_be),
      .rdata (w_arr_rdata)
   );

   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = (r_state == ST_RESP);
   assign resp_err   = r_err;
   assign resp_rdata = r_rd_sel ? w_arr_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mem_bank_hs                                                 |
// | Brief   : Scoreboard bench for mem_bank_hs at LATENCY=1 and LATENCY=3.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_bank_hs;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BW = 4;

   logic           clk = 1'b0;
   logic           reset_n    [2];
   logic           req_valid  [2];
   logic           req_ready  [2];
   logic           req_write  [2];
   logic [AW-1:0]  req_addr   [2];
   logic [DW-1:0]  req_wdata  [2];
   logic [BW-1:0]  req_be     [2];
   logic           resp_valid [2];
   logic           resp_ready [2];
   logic [DW-1:0]  resp_rdata [2];
   logic           resp_err   [2];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl[int];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   mem_bank_hs #(.DATA_W(DW), .DEPTH(1024), .ADDR_W(AW), .LATENCY(1)) u_dut0 (
      .clk(clk), .reset_n(reset_n[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
   );

   mem_bank_hs #(.DATA_W(DW), .DEPTH(1024), .ADDR_W(AW), .LATENCY(3)) u_dut1 (
      .clk(clk), .reset_n(reset_n[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic addr_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
   endfunction

   // abort: 0 = normal, 1 = reset while in WAIT, 2 = reset while in RESP
   task automatic do_req(input int d, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input int hold, input int abort);
      exp_t        e;
      logic        err;
      int          key;
      int          n;
      int          lat;
      logic [31:0] cur;
      logic [31:0] s_rd;
      logic        s_err;
      logic        bad;
      lat = (d == 0) ? 1 : 3;
      err = addr_err(a);
      key = d * 4096 + int'(a[11:2]);

      @(negedge clk);
      chk("req_ready_idle", 64'(req_ready[d]), 64'(1));
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      req_be[d]    = be;
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      req_write[d] = 1'($urandom);
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      req_be[d]    = 4'($urandom);

      e.err   = err;
      e.rdata = 32'h0;
      if (!err) begin
         if (wr) begin
            if (abort != 1) begin
               cur = mdl.exists(key) ? mdl[key] : 32'h0;
               for (int i = 0; i < BW; i++) begin
                  if (be[i]) cur[i*8 +: 8] = wd[i*8 +: 8];
               end
               mdl[key] = cur;
            end
         end else begin
            e.rdata = mdl[key];
         end
      end
      if (abort == 0) sb.push_back(e);

      if (abort == 1) begin
         @(negedge clk);
         reset_n[d] = 1'b0;
         @(negedge clk);
         reset_n[d] = 1'b1;
         bad = 1'b0;
         for (int i = 0; i < lat + 3; i++) begin
            @(negedge clk);
            if (resp_valid[d] !== 1'b0) bad = 1'b1;
         end
         chk("no_spurious_resp", 64'(bad), 64'(0));
         chk("ready_after_abort", 64'(req_ready[d]), 64'(1));
         return;
      end

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (resp_valid[d] !== 1'b1 && n < 50);
      chk("latency", 64'(n), 64'(lat + 1));

      if (abort == 2) begin
         reset_n[d] = 1'b0;
         @(negedge clk);
         reset_n[d] = 1'b1;
         chk("resp_valid_after_rst", 64'(resp_valid[d]), 64'(0));
         chk("resp_rdata_after_rst", 64'(resp_rdata[d]), 64'(0));
         return;
      end

      s_rd  = resp_rdata[d];
      s_err = resp_err[d];
      if (hold > 0) begin
         bad = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_rdata[d] !== s_rd || resp_err[d] !== s_err ||
                req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b1) bad = 1'b1;
         end
         chk("backpressure_stable", 64'(bad), 64'(0));
      end

      resp_ready[d] = 1'b1;
      @(posedge clk);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 64'(1), 64'(0));
      end else begin
         e = sb.pop_front();
         chk("resp_rdata", 64'(s_rd), 64'(e.rdata));
         chk("resp_err", 64'(s_err), 64'(e.err));
      end
      #1;
      resp_ready[d] = 1'b0;
      chk("req_ready_after_resp", 64'(req_ready[d]), 64'(1));
      chk("resp_valid_dropped", 64'(resp_valid[d]), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         reset_n[d]    = 1'b0;
         req_valid[d]  = 1'b0;
         req_write[d]  = 1'b0;
         req_addr[d]   = '0;
         req_wdata[d]  = '0;
         req_be[d]     = '0;
         resp_ready[d] = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", 64'(req_ready[d]), 64'(1));
         chk("rst_resp_valid", 64'(resp_valid[d]), 64'(0));
         chk("rst_resp_err", 64'(resp_err[d]), 64'(0));
         chk("rst_resp_rdata", 64'(resp_rdata[d]), 64'(0));
         reset_n[d] = 1'b1;
      end

      // LATENCY=1: full write, read back, byte-enable merge
      do_req(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 0);
      do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, 0);
      do_req(0, 1'b1, 32'h40, 32'h11223344, 4'b0101, 0, 0);
      do_req(0, 1'b0, 32'h40, 32'h0, 4'hF, 0, 0);

      // errors, no-op write, range-error write must not alias onto word 0
      do_req(0, 1'b0, 32'h42, 32'h0, 4'h0, 0, 0);
      do_req(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, 0);
      do_req(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0);
      do_req(0, 1'b1, 32'h0, 32'h12345678, 4'h0, 0, 0);
      do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0);
      do_req(0, 1'b1, 32'h3, 32'h77777777, 4'hF, 0, 0);
      do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0);

      // backpressure
      do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 5, 0);

      // committed write survives a reset in RESP
      do_req(0, 1'b1, 32'h44, 32'hA5A55A5A, 4'hF, 0, 2);
      do_req(0, 1'b0, 32'h44, 32'h0, 4'h0, 0, 0);

      // LATENCY=3: write aborted in WAIT is never committed
      do_req(1, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 0, 0);
      do_req(1, 1'b1, 32'h80, 32'h00000005, 4'hF, 0, 1);
      do_req(1, 1'b0, 32'h80, 32'h0, 4'h0, 0, 0);
      do_req(1, 1'b1, 32'h84, 32'h01020304, 4'b1010, 2, 0);
      do_req(1, 1'b0, 32'h84, 32'h0, 4'h0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
